// File: rtl/dtree_feature_loader_if.sv
// Byte-serial feature stream and class result stream between a feature source and the tree loader.
// The master side supplies feature bytes and consumes results; the loader is the slave.
interface dtree_feature_loader_if #(
    parameter int FEAT_W  = 8,
    parameter int CLASS_W = 2
);
    logic               s_valid;
    logic               s_ready;
    logic [FEAT_W-1:0]  s_data;
    logic               s_last;
    logic               m_valid;
    logic               m_ready;
    logic [CLASS_W-1:0] m_class;

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_class
    );

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_class
    );
endinterface

// File: rtl/dtree_feature_loader.sv
// Assembles a byte-serial feature frame onto the parallel tree bus, waits out the tree settle
// time, then returns the sampled class. Optional per-class result counters: DTREE_CLASS_COUNT_EN.
//
// state  | meaning
// LOAD   | accepting frame bytes into slot idx
// SETTLE | full frame on feat_bus, counting settle cycles
// OUT    | class latched, m_valid held until m_ready
// DRAIN  | over-long frame, discarding bytes until s_last
module dtree_feature_loader #(
    parameter int NUM_FEAT   = 18,
    parameter int FEAT_W     = 8,
    parameter int SETTLE_CYC = 4,
    parameter int CLASS_W    = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    dtree_feature_loader_if.slave        bus,
    output logic [NUM_FEAT*FEAT_W-1:0]   feat_bus,
    input  logic [CLASS_W-1:0]           class_in,
    output logic                         busy,
    output logic                         err_len
`ifdef DTREE_CLASS_COUNT_EN
    ,
    output logic [(1<<CLASS_W)*16-1:0]   class_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_FEAT);

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SETTLE = 2'd1,
        OUT    = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] idx;
    logic [7:0]       cnt;
    logic             s_xfer;
    logic             m_xfer;
    logic             at_last;
    logic             settle_done;

    assign s_xfer      = bus.s_valid && bus.s_ready;
    assign m_xfer      = bus.m_valid && bus.m_ready;
    assign at_last     = (idx == IDX_W'(NUM_FEAT - 1));
    assign settle_done = (cnt == 8'(SETTLE_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD: begin
                if (s_xfer && at_last) begin
                    state_nxt = bus.s_last ? SETTLE : DRAIN;
                end
            end
            SETTLE: begin
                if (settle_done) begin
                    state_nxt = OUT;
                end
            end
            OUT: begin
                if (m_xfer) begin
                    state_nxt = LOAD;
                end
            end
            DRAIN: begin
                if (s_xfer && bus.s_last) begin
                    state_nxt = LOAD;
                end
            end
            default: state_nxt = LOAD;
        endcase
    end

    always_comb begin
        bus.s_ready = (state == LOAD) || (state == DRAIN);
        bus.m_valid = (state == OUT);
        busy        = !((state == LOAD) && (idx == '0));
    end

    // Short and long frames both pulse err_len; only a long frame detours through DRAIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx         <= '0;
            cnt         <= '0;
            feat_bus    <= '0;
            bus.m_class <= '0;
            err_len     <= 1'b0;
        end else begin
            err_len <= 1'b0;
            case (state)
                LOAD: begin
                    if (s_xfer) begin
                        feat_bus[idx*FEAT_W +: FEAT_W] <= bus.s_data;
                        if (!at_last) begin
                            if (bus.s_last) begin
                                err_len <= 1'b1;
                                idx     <= '0;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end else begin
                            idx <= '0;
                            cnt <= '0;
                            if (!bus.s_last) begin
                                err_len <= 1'b1;
                            end
                        end
                    end
                end
                SETTLE: begin
                    cnt <= cnt + 8'd1;
                    if (settle_done) begin
                        bus.m_class <= class_in;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DTREE_CLASS_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            class_cnt <= '0;
        end else if (m_xfer && (class_cnt[bus.m_class*16 +: 16] != 16'hFFFF)) begin
            class_cnt[bus.m_class*16 +: 16] <= class_cnt[bus.m_class*16 +: 16] + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dtree_feature_loader.sv
// Scoreboard bench for dtree_feature_loader: frame-level reference model feeds expected
// results and error pulses into queues that an independent monitor pops and compares.
module tb_dtree_feature_loader;

    localparam int NUM_FEAT   = 18;
    localparam int FEAT_W     = 8;
    localparam int SETTLE_CYC = 4;
    localparam int CLASS_W    = 2;
    localparam int FB_W       = NUM_FEAT * FEAT_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dtree_feature_loader_if #(.FEAT_W(FEAT_W), .CLASS_W(CLASS_W)) bus ();

    logic [FB_W-1:0]    feat_bus;
    logic [CLASS_W-1:0] class_in;
    logic               busy;
    logic               err_len;
`ifdef DTREE_CLASS_COUNT_EN
    logic [(1<<CLASS_W)*16-1:0] class_cnt;
`endif

    dtree_feature_loader #(
        .NUM_FEAT(NUM_FEAT), .FEAT_W(FEAT_W), .SETTLE_CYC(SETTLE_CYC), .CLASS_W(CLASS_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .feat_bus (feat_bus),
        .class_in (class_in),
        .busy     (busy),
        .err_len  (err_len)
`ifdef DTREE_CLASS_COUNT_EN
        ,
        .class_cnt(class_cnt)
`endif
    );

    typedef struct {
        logic [CLASS_W-1:0] cls;
        logic [FB_W-1:0]    feat;
        int                 rise;
    } res_t;

    res_t            res_q[$];
    logic [FB_W-1:0] err_q[$];
    res_t            r;
    logic [FB_W-1:0] e;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int force_cls = -1;
    int bp_cycles = 0;
    bit rand_ready = 0;
    logic [CLASS_W-1:0] cls_hist [int];
    logic [FB_W-1:0]    mdl_feat;
    int                 mdl_cnt [4];
    logic               mv_prev = 1'b0;

    function automatic void chk(string name, logic [FB_W-1:0] act, logic [FB_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Cycle counter and a free-running random class input, logged per cycle.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        class_in = (force_cls >= 0) ? CLASS_W'(force_cls) : CLASS_W'($urandom);
        cls_hist[cyc] = class_in;
    end

    always @(posedge clk) begin
        #1;
        if (bp_cycles > 0) begin
            bus.m_ready = 1'b0;
            if (bus.m_valid) bp_cycles--;
        end else begin
            bus.m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            mv_prev = 1'b0;
        end else begin
            if (bus.m_valid && !mv_prev) begin
                if (res_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_m_valid: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    chk("m_valid_latency_cycle", FB_W'(cyc), FB_W'(res_q[0].rise));
                    chk("s_ready_during_out", FB_W'(bus.s_ready), '0);
                end
            end
            if (bus.m_valid && bus.m_ready && res_q.size() > 0) begin
                r = res_q.pop_front();
                chk("m_class", FB_W'(bus.m_class), FB_W'(r.cls));
                chk("feat_bus_at_result", feat_bus, r.feat);
            end
            if (err_len) begin
                if (err_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_err_len: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    e = err_q.pop_front();
                    chk("feat_bus_at_err", feat_bus, e);
                end
            end
            mv_prev = bus.m_valid;
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic last);
        int n = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = b;
        bus.s_last  = last;
        @(negedge clk);
        while (!bus.s_ready && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (!bus.s_ready) begin
            checks++; errors++;
            $display("FAIL s_ready_timeout: got 0 expected 1 (cycle %0d)", cyc);
        end
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    // Frame-level model: a frame writes min(len, NUM_FEAT) slots; only len == NUM_FEAT yields a result.
    task automatic send_frame(input int len, input bit seq, input bit gaps);
        logic [7:0]      bytes[$];
        logic [FB_W-1:0] snap;
        int              a;
        int              g;
        res_t            x;
        snap = mdl_feat;
        for (int i = 0; i < len; i++) begin
            bytes.push_back(seq ? 8'(i) : 8'($urandom));
            if (i < NUM_FEAT) snap[i*FEAT_W +: FEAT_W] = bytes[i];
        end
        mdl_feat = snap;
        if (len != NUM_FEAT) err_q.push_back(snap);
        for (int i = 0; i < len; i++) begin
            if (gaps) begin
                g = $urandom_range(0, 2);
                repeat (g) begin
                    @(posedge clk);
                    #1;
                end
            end
            send_byte(bytes[i], (i == len - 1));
        end
        a = cyc;
        if (len == NUM_FEAT) begin
            repeat (SETTLE_CYC) @(negedge clk);
            x.cls  = cls_hist[a + SETTLE_CYC - 1];
            x.feat = snap;
            x.rise = a + SETTLE_CYC;
            res_q.push_back(x);
            mdl_cnt[x.cls]++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((res_q.size() != 0 || err_q.size() != 0) && n < 500) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (res_q.size() != 0 || err_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d pending expected 0", name, res_q.size() + err_q.size());
            res_q.delete();
            err_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rr;
        int len;
        rst         = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b1;
        class_in    = '0;
        mdl_feat    = '0;
        for (int k = 0; k < 4; k++) mdl_cnt[k] = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_feat_bus", feat_bus, '0);
        chk("reset_m_valid", FB_W'(bus.m_valid), '0);
        chk("reset_m_class", FB_W'(bus.m_class), '0);
        chk("reset_err_len", FB_W'(err_len), '0);
        chk("reset_busy", FB_W'(busy), '0);
        chk("reset_s_ready", FB_W'(bus.s_ready), FB_W'(1));
        @(posedge clk);
        #1;

        // Nominal frame 0x00..0x11 with class 3.
        force_cls = 3;
        send_frame(NUM_FEAT, 1'b1, 1'b0);
        wait_idle("nominal");
        force_cls = -1;
        chk("nominal_slot0", FB_W'(feat_bus[7:0]), FB_W'(8'h00));
        chk("nominal_slot17", FB_W'(feat_bus[143:136]), FB_W'(8'h11));
        @(negedge clk);
        chk("idle_s_ready", FB_W'(bus.s_ready), FB_W'(1));
        chk("idle_busy", FB_W'(busy), '0);
        @(posedge clk);
        #1;

        // Backpressure: 10 cycles of m_ready=0 while class_in keeps changing.
        bp_cycles = 10;
        send_frame(NUM_FEAT, 1'b0, 1'b0);
        wait_idle("backpressure");

        // Short frame then a full frame.
        send_frame(5, 1'b0, 1'b0);
        send_frame(NUM_FEAT, 1'b0, 1'b0);
        wait_idle("short");

        // Long frame: bytes past the last slot are discarded.
        send_frame(20, 1'b0, 1'b0);
        wait_idle("long");
        @(negedge clk);
        chk("long_feat_bus_kept", feat_bus, mdl_feat);
        chk("long_back_to_load_s_ready", FB_W'(bus.s_ready), FB_W'(1));
        chk("long_back_to_load_busy", FB_W'(busy), '0);
        @(posedge clk);
        #1;

        // Reset two cycles after the final byte of a frame.
        for (int i = 0; i < NUM_FEAT; i++) send_byte(8'($urandom), (i == NUM_FEAT - 1));
        @(negedge clk);
        chk("settle_busy", FB_W'(busy), FB_W'(1));
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mdl_feat = '0;
        for (int k = 0; k < 4; k++) mdl_cnt[k] = 0;
        @(negedge clk);
        chk("rst_mid_settle_m_valid", FB_W'(bus.m_valid), '0);
        chk("rst_mid_settle_feat_bus", feat_bus, '0);
        chk("rst_mid_settle_s_ready", FB_W'(bus.s_ready), FB_W'(1));
        repeat (10) @(posedge clk);
        #1;

        // Randomized mix of frame lengths, byte gaps and result backpressure.
        rand_ready = 1'b1;
        for (int f = 0; f < 40; f++) begin
            rr = $urandom_range(0, 99);
            if (rr < 70)      len = NUM_FEAT;
            else if (rr < 85) len = $urandom_range(1, NUM_FEAT - 1);
            else              len = $urandom_range(NUM_FEAT + 1, NUM_FEAT + 4);
            send_frame(len, 1'b0, 1'b1);
        end
        wait_idle("random");
        rand_ready = 1'b0;

`ifdef DTREE_CLASS_COUNT_EN
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk("class_cnt", FB_W'(class_cnt[k*16 +: 16]),
                FB_W'((mdl_cnt[k] > 65535) ? 65535 : mdl_cnt[k]));
        end
`endif

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

endmodule
